// File: rtl/led_seq_pkg.sv
// Mode encoding shared by the LED sequencer blocks.
// Pure type/constant package; no logic, no latency, no backpressure.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_GRAY    = 2'd3
  } mode_t;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: free-running count with a one-cycle tick at all-ones, sync clear.
// Latency: tick is decoded directly from the count register; no backpressure.
module led_prescaler #(
  parameter int PRESC_W = 22
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == '1);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer (binary, scan, breathe, gray) selected by an async MODE input.
// Latency: 1 clock state-to-LED, 4 clocks MODE-to-LED; free-running, no backpressure.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED   = 8,
  parameter int PRESC_W = 22,
  parameter int PWM_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  output logic [N_LED-1:0] LED
);

  localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_LED - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic [1:0]       mode_s1, mode_s2;
  mode_t            mode_q;
  logic             mode_chg;
  logic             tick;
  logic [N_LED-1:0] step;
  logic [POS_W-1:0] pos;
  logic             scan_up;
  logic [PWM_W-1:0] duty;
  logic             duty_up;
  logic [PWM_W-1:0] pwm_cnt;
  logic [N_LED-1:0] led_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_s1 <= '0;
      mode_s2 <= '0;
    end else begin
      mode_s1 <= MODE;
      mode_s2 <= mode_s1;
    end
  end

  assign mode_chg = (mode_s2 != mode_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           mode_q <= MODE_BIN;
    else if (mode_chg) mode_q <= mode_t'(mode_s2);
  end

  led_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (mode_chg),
    .tick (tick)
  );

  // A mode change restarts every pattern from its origin, overriding a coincident tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step    <= '0;
      pos     <= '0;
      scan_up <= 1'b1;
      duty    <= '0;
      duty_up <= 1'b1;
    end else if (mode_chg) begin
      step    <= '0;
      pos     <= '0;
      scan_up <= 1'b1;
      duty    <= '0;
      duty_up <= 1'b1;
    end else if (tick) begin
      step <= step + 1'b1;

      if (N_LED == 1) begin
        pos <= '0;
      end else if (scan_up) begin
        if (pos == POS_MAX) begin
          scan_up <= 1'b0;
          pos     <= pos - 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          scan_up <= 1'b1;
          pos     <= pos + 1'b1;
        end else begin
          pos <= pos - 1'b1;
        end
      end

      // Direction flips on the tick that lands on an end value, so each end shows once.
      if (duty_up) begin
        duty <= duty + 1'b1;
        if (duty == DUTY_MAX - 1'b1) duty_up <= 1'b0;
      end else begin
        duty <= duty - 1'b1;
        if (duty == PWM_W'(1)) duty_up <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BIN:     led_d = step;
      MODE_SCAN:    led_d = N_LED'(1) << pos;
      MODE_BREATHE: led_d = {N_LED{pwm_cnt < duty}};
      MODE_GRAY:    led_d = step ^ (step >> 1);
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) LED <= '0;
    else     LED <= led_d;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench: a timeline reference model queues expected LED values per clock,
// a monitor pops and compares them for a 4-LED and a 1-LED instance.
module tb_led_sequencer;

  localparam int PRESC_W = 3;
  localparam int PWM_W   = 3;
  localparam int STEP    = 1 << PRESC_W;
  localparam int PWM_P   = 1 << PWM_W;

  logic       CLK  = 1'b0;
  logic       RST  = 1'b1;
  logic [1:0] MODE = 2'd0;
  logic [3:0] led4;
  logic [0:0] led1;

  int checks = 0;
  int errors = 0;

  led_sequencer #(.N_LED(4), .PRESC_W(PRESC_W), .PWM_W(PWM_W)) dut4 (
    .CLK  (CLK),
    .RST  (RST),
    .MODE (MODE),
    .LED  (led4)
  );

  led_sequencer #(.N_LED(1), .PRESC_W(PRESC_W), .PWM_W(PWM_W)) dut1 (
    .CLK  (CLK),
    .RST  (RST),
    .MODE (MODE),
    .LED  (led1)
  );

  always #5 CLK = ~CLK;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected LED for n LEDs, given the mode, ticks since the mode took effect and PWM phase.
  function automatic logic [31:0] exp_led(int n, int mode, int k, int pwm);
    int c, per, m, p, d, full;
    full = (1 << n) - 1;
    case (mode)
      0: return 32'(k % (1 << n));
      3: begin
        c = k % (1 << n);
        return 32'(c ^ (c >> 1));
      end
      1: begin
        if (n == 1) return 32'd1;
        per = 2 * (n - 1);
        m   = k % per;
        p   = (m < n) ? m : per - m;
        return 32'(1 << p);
      end
      default: begin
        per = 2 * (PWM_P - 1);
        m   = k % per;
        d   = (m <= PWM_P - 1) ? m : per - m;
        return (pwm < d) ? 32'(full) : 32'd0;
      end
    endcase
  endfunction

  int         ne = 0;   // edges since reset release
  int         le = 0;   // edge at which the current mode took effect
  int         am = 0;   // mode currently in effect
  int         samp[$];  // MODE value seen at each edge
  logic [3:0] q4[$];
  logic [0:0] q1[$];

  initial forever begin : model
    int k, pw, m2;
    @(posedge CLK or posedge RST);
    if (RST) begin
      ne = 0; le = 0; am = 0;
      samp.delete(); q4.delete(); q1.delete();
    end else begin
      k  = (ne - le) / STEP;
      pw = ne % PWM_P;
      q4.push_back(4'(exp_led(4, am, k, pw)));
      q1.push_back(1'(exp_led(1, am, k, pw)));
      samp.push_back(int'(MODE));
      // A MODE value seen at edge e takes effect two edges later.
      m2 = (samp.size() >= 3) ? samp[samp.size() - 3] : 0;
      if (m2 != am) begin
        am = m2;
        le = ne + 1;
      end
      ne = ne + 1;
    end
  end

  initial forever begin : monitor
    logic [3:0] e4;
    logic [0:0] e1;
    @(negedge CLK);
    if (RST) begin
      check("rst_led4", 32'(led4), 32'd0);
      check("rst_led1", 32'(led1), 32'd0);
    end else if (q4.size() > 0) begin
      e4 = q4.pop_front();
      e1 = q1.pop_front();
      check($sformatf("led4_mode%0d", am), 32'(led4), 32'(e4));
      check($sformatf("led1_mode%0d", am), 32'(led1), 32'(e1));
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  initial begin
    run(3);
    RST = 1'b0;
    run(STEP * 18);                          // BIN through the 15->0 wrap

    RST = 1'b1; MODE = 2'd1; run(2);
    RST = 1'b0; run(STEP * 10);              // SCAN straight out of reset

    MODE = 2'd3; run(STEP * 18);             // GRAY including wrap
    MODE = 2'd2; run(STEP * 31);             // BREATHE, two full triangles
    MODE = 2'd1; run(STEP * 22);             // SCAN; 1-LED instance held lit

    // Mid-count BIN -> SCAN: new pattern appears exactly 4 clocks after the MODE edge.
    MODE = 2'd0; RST = 1'b1; run(2);
    RST = 1'b0; run(STEP * 5 + 3);
    MODE = 2'd1;
    repeat (3) @(posedge CLK);
    #1 check("chg_lat3_not_scan", 32'(led4 == 4'b0001), 32'd0);
    @(posedge CLK);
    #1 check("chg_lat4_scan", 32'(led4), 32'h1);
    run(STEP * 2);

    // Reset pulse inside the mode-change window aborts it; SCAN restarts cleanly.
    MODE = 2'd0; RST = 1'b1; run(2);
    RST = 1'b0; run(STEP * 3 + 5);
    MODE = 2'd1; run(2);
    RST = 1'b1;
    #1 check("rst_async_led4", 32'(led4), 32'd0);
    run(1);
    RST = 1'b0;
    run(STEP * 9);

    for (int i = 0; i < 16; i++) begin
      MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        RST = 1'b1; run(1);
        RST = 1'b0;
      end
      run($urandom_range(1, 70));
    end
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
